// File: rtl/tlul_sram_adapter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tlul_sram_adapter_if : TL-UL A/D channel bundle between crossbar and device
// Rev 1.0
// ---------------------------------------------------------------------------
interface tlul_sram_adapter_if;
  // A channel (host -> device)
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  // D channel (device -> host)
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic        d_user;
  logic        d_error;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error
  );
endinterface
`default_nettype wire

// File: rtl/tlul_sram_adapter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tlul_sram_adapter : TL-UL device front-end for a 1-cycle-latency SRAM macro
// Rev 1.0
// ---------------------------------------------------------------------------
module tlul_sram_adapter #(
  parameter int SramAw      = 12,
  parameter int SramDw      = 32,
  parameter int Outstanding = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  tlul_sram_adapter_if.slave  tl,
  output logic                req_o,
  output logic                we_o,
  output logic [SramAw-1:0]   addr_o,
  output logic [SramDw-1:0]   wdata_o,
  output logic [SramDw-1:0]   wmask_o,
  input  logic [SramDw-1:0]   rdata_i
);

  localparam logic [2:0] OpPutFull       = 3'd0;
  localparam logic [2:0] OpPutPartial    = 3'd1;
  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  localparam int              CntW    = $clog2(Outstanding + 1);
  localparam int              PtrW    = $clog2(Outstanding);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(Outstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Outstanding - 1);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        size;
    logic [7:0]        source;
    logic              error;
    logic [SramDw-1:0] data;
  } rsp_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  logic [3:0]      lanes_w;
  logic            misalign_w;
  logic            bad_op_w;
  logic            err_w;
  logic            accept_w;
  logic            d_hs_w;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Stage 1: metadata of the request accepted last cycle, waiting for rdata_i.
  logic            s1_valid_q;
  logic [2:0]      s1_opcode_q;
  logic [1:0]      s1_size_q;
  logic [7:0]      s1_source_q;
  logic            s1_error_q;
  logic            s1_read_q;

  rsp_t            mem_q [Outstanding];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] fcnt_q, fcnt_d;
  rsp_t            push_rsp_w;
  rsp_t            head_w;

  logic unused_bits;
  assign unused_bits = ^{tl.a_param, tl.a_address[31:SramAw+2]};

  always_comb begin
    lanes_w    = 4'b0000;
    misalign_w = 1'b0;
    case (tl.a_size)
      2'd0: lanes_w = 4'b0001 << tl.a_address[1:0];
      2'd1: begin
        lanes_w    = 4'b0011 << tl.a_address[1:0];
        misalign_w = tl.a_address[0];
      end
      2'd2: begin
        lanes_w    = 4'b1111;
        misalign_w = |tl.a_address[1:0];
      end
      default: ;
    endcase
  end

  assign bad_op_w = (tl.a_opcode != OpPutFull) && (tl.a_opcode != OpPutPartial) &&
                    (tl.a_opcode != OpGet);
  assign err_w    = bad_op_w || (tl.a_size > 2'd2) || misalign_w ||
                    (|(tl.a_mask & ~lanes_w)) ||
                    ((tl.a_opcode == OpPutFull) && (tl.a_mask != lanes_w));

  assign tl.a_ready = (cnt_q < MaxCnt);
  assign accept_w   = tl.a_valid && tl.a_ready;
  assign d_hs_w     = tl.d_valid && tl.d_ready;

  assign req_o   = accept_w && !err_w;
  assign we_o    = (tl.a_opcode == OpPutFull) || (tl.a_opcode == OpPutPartial);
  assign addr_o  = tl.a_address[SramAw+1:2];
  assign wdata_o = tl.a_data;

  for (genvar gi = 0; gi < SramDw / 8; gi++) begin : g_wmask
    assign wmask_o[8*gi +: 8] = {8{tl.a_mask[gi]}};
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept_w && !d_hs_w) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!accept_w && d_hs_w) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_opcode_q <= 3'd0;
      s1_size_q   <= 2'd0;
      s1_source_q <= 8'd0;
      s1_error_q  <= 1'b0;
      s1_read_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= accept_w;
      if (accept_w) begin
        s1_opcode_q <= (tl.a_opcode == OpGet) ? OpAccessAckData : OpAccessAck;
        s1_size_q   <= tl.a_size;
        s1_source_q <= tl.a_source;
        s1_error_q  <= err_w;
        s1_read_q   <= (tl.a_opcode == OpGet);
      end
    end
  end

  // Errored reads never strobed the SRAM, so rdata_i is meaningless for them.
  always_comb begin
    push_rsp_w.opcode = s1_opcode_q;
    push_rsp_w.size   = s1_size_q;
    push_rsp_w.source = s1_source_q;
    push_rsp_w.error  = s1_error_q;
    push_rsp_w.data   = (s1_read_q && !s1_error_q) ? rdata_i : '0;
  end

  always_comb begin
    fcnt_d = fcnt_q;
    if (s1_valid_q && !d_hs_w) begin
      fcnt_d = fcnt_q + 1'b1;
    end else if (!s1_valid_q && d_hs_w) begin
      fcnt_d = fcnt_q - 1'b1;
    end
  end

  // cnt covers stage 1 plus the FIFO, so a push never meets a full FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Outstanding; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (s1_valid_q) begin
        mem_q[wptr_q] <= push_rsp_w;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (d_hs_w) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      fcnt_q <= fcnt_d;
    end
  end

  assign tl.d_valid  = (fcnt_q != '0);
  assign head_w      = tl.d_valid ? mem_q[rptr_q] : '0;
  assign tl.d_opcode = head_w.opcode;
  assign tl.d_size   = head_w.size;
  assign tl.d_source = head_w.source;
  assign tl.d_error  = head_w.error;
  assign tl.d_data   = head_w.data;
  assign tl.d_param  = 3'd0;
  assign tl.d_sink   = 1'b0;
  assign tl.d_user   = 1'b0;

endmodule
`default_nettype wire
